// File: rtl/mult_arb.sv
// rtl/mult_arb.sv - two-requester round-robin arbiter feeding a 3-stage Q15 multiplier pipeline
module mult_arb #(
    parameter int DW   = 16,
    parameter int FRAC = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          res0_valid,
    output logic [DW-1:0] res0_data,
    output logic          res1_valid,
    output logic [DW-1:0] res1_data,
    output logic          busy
);

    localparam logic [2*DW-1:0] SAT_PROD = {2'b01, {(2*DW-2){1'b0}}};
    localparam logic [DW-1:0]   SAT_RES  = {1'b0, {(DW-1){1'b1}}};

    logic                   prio;
    logic                   xfer;
    logic [DW-1:0]          sel_a;
    logic [DW-1:0]          sel_b;

    logic                   s1_valid;
    logic                   s1_tag;
    logic signed [DW-1:0]   s1_a;
    logic signed [DW-1:0]   s1_b;

    logic                   s2_valid;
    logic                   s2_tag;
    logic signed [2*DW-1:0] s2_prod;
    logic signed [2*DW-1:0] prod_full;
    logic [DW-1:0]          slice;

    // Readies are forced low during reset so nothing is granted while the pipeline is cleared.
    always_comb begin
        req0_ready = rst && en && req0_valid && (!req1_valid || !prio);
        req1_ready = rst && en && req1_valid && (!req0_valid ||  prio);
    end

    assign xfer  = req0_ready || req1_ready;
    assign sel_a = req1_ready ? req1_a : req0_a;
    assign sel_b = req1_ready ? req1_b : req0_b;

    assign prod_full = s1_a * s1_b;

    // The only product whose slice overflows is (-1.0)*(-1.0); clamp it to the largest positive value.
    assign slice = (s2_prod == SAT_PROD) ? SAT_RES : s2_prod[FRAC+DW-1:FRAC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio       <= 1'b0;
            s1_valid   <= 1'b0;
            s1_tag     <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s2_valid   <= 1'b0;
            s2_tag     <= 1'b0;
            s2_prod    <= '0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_data  <= '0;
            res1_data  <= '0;
        end else begin
            if (xfer) begin
                prio <= !req1_ready;
                s1_a <= {~sel_a[DW-1], sel_a[DW-2:0]};
                s1_b <= {~sel_b[DW-1], sel_b[DW-2:0]};
            end
            s1_valid <= xfer;
            s1_tag   <= req1_ready;

            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_prod  <= prod_full;

            res0_valid <= s2_valid && !s2_tag;
            res1_valid <= s2_valid &&  s2_tag;
            if (s2_valid && !s2_tag) res0_data <= slice;
            if (s2_valid &&  s2_tag) res1_data <= slice;
        end
    end

    assign busy = s1_valid || s2_valid || res0_valid || res1_valid;

endmodule

// File: tb/tb_mult_arb.sv
// tb/tb_mult_arb.sv - directed self-checking bench for mult_arb
module tb_mult_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req0_ready;
    logic        req1_ready;
    logic        res0_valid;
    logic [15:0] res0_data;
    logic        res1_valid;
    logic [15:0] res1_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mult_arb #(.DW(16), .FRAC(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .res0_valid (res0_valid),
        .res0_data  (res0_data),
        .res1_valid (res1_valid),
        .res1_data  (res1_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b1;
        req0_valid = 1'b1; req0_a = 16'hC000; req0_b = 16'hC000;
        req1_valid = 1'b1; req1_a = 16'hC000; req1_b = 16'hC000;
        #3;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        step; step;
        n_cmp++; if ({res0_valid, res1_valid, busy} !== 3'b000) begin n_err++; $display("FAIL reset_valid_busy got=%b exp=000", {res0_valid, res1_valid, busy}); end
        n_cmp++; if (res0_data !== 16'h0000 || res1_data !== 16'h0000) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0000/0000", res0_data, res1_data); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        step;
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_a = 16'hC000; req0_b = 16'hC000;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        for (int c = 1; c <= 4; c++) begin
            step;
            if (c == 1) req0_valid = 1'b0;
            n_cmp++; if (res0_valid !== (c == 3)) begin n_err++; $display("FAIL single_res0_valid c=%0d got=%b exp=%b", c, res0_valid, (c == 3)); end
            n_cmp++; if (res1_valid !== 1'b0) begin n_err++; $display("FAIL single_res1_valid c=%0d got=%b exp=0", c, res1_valid); end
            n_cmp++; if (busy !== (c <= 3)) begin n_err++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, (c <= 3)); end
            if (c == 3) begin
                n_cmp++; if (res0_data !== 16'h2000) begin n_err++; $display("FAIL single_data got=%h exp=2000", res0_data); end
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [15:0] ve [2];
        va[0] = 16'h0000; vb[0] = 16'h0000; ve[0] = 16'h7FFF;
        va[1] = 16'h0000; vb[1] = 16'hFFFF; ve[1] = 16'h8001;
        for (int v = 0; v < 2; v++) begin
            req1_valid = 1'b1; req1_a = va[v]; req1_b = vb[v];
            #1;
            n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL sat_ready v=%0d got=%b exp=01", v, {req0_ready, req1_ready}); end
            for (int c = 1; c <= 3; c++) begin
                step;
                if (c == 1) req1_valid = 1'b0;
                n_cmp++; if (res1_valid !== (c == 3)) begin n_err++; $display("FAIL sat_res1_valid v=%0d c=%0d got=%b exp=%b", v, c, res1_valid, (c == 3)); end
            end
            n_cmp++; if (res1_data !== ve[v]) begin n_err++; $display("FAIL sat_data v=%0d got=%h exp=%h", v, res1_data, ve[v]); end
            n_cmp++; if (res0_valid !== 1'b0 || res0_data !== 16'h2000) begin n_err++; $display("FAIL sat_res0_untouched v=%0d got=%b/%h exp=0/2000", v, res0_valid, res0_data); end
            step;
        end
    endtask

    task automatic test_contention;
        rst = 1'b0;
        step;
        rst = 1'b1;
        step;
        req0_valid = 1'b1; req0_a = 16'hC000; req0_b = 16'hC000;
        req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'hC000;
        #1;
        for (int c = 0; c <= 9; c++) begin
            if (c < 6) begin
                n_cmp++; if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_grant c=%0d got=%b", c, {req0_ready, req1_ready}); end
            end
            if (c >= 3 && c <= 8) begin
                n_cmp++; if ({res0_valid, res1_valid} !== (((c - 3) % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_res c=%0d got=%b", c, {res0_valid, res1_valid}); end
                if ((c - 3) % 2 == 0) begin
                    n_cmp++; if (res0_data !== 16'h2000) begin n_err++; $display("FAIL cont_res0_data c=%0d got=%h exp=2000", c, res0_data); end
                end else begin
                    n_cmp++; if (res1_data !== 16'hE000) begin n_err++; $display("FAIL cont_res1_data c=%0d got=%h exp=E000", c, res1_data); end
                end
            end else begin
                n_cmp++; if ({res0_valid, res1_valid} !== 2'b00) begin n_err++; $display("FAIL cont_idle c=%0d got=%b exp=00", c, {res0_valid, res1_valid}); end
            end
            step;
            if (c == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
    endtask

    task automatic test_en_gating;
        req0_valid = 1'b1; req0_a = 16'hC000; req0_b = 16'hC000;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL en_first_grant got=%b exp=1", req0_ready); end
        for (int c = 1; c <= 6; c++) begin
            step;
            if (c == 1) begin en = 1'b0; req1_valid = 1'b1; #1; end
            n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL en_ready c=%0d got=%b exp=00", c, {req0_ready, req1_ready}); end
            n_cmp++; if ({res0_valid, res1_valid} !== ((c == 3) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL en_res c=%0d got=%b", c, {res0_valid, res1_valid}); end
            n_cmp++; if (busy !== (c <= 3)) begin n_err++; $display("FAIL en_busy c=%0d got=%b exp=%b", c, busy, (c <= 3)); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
        step;
    endtask

    task automatic test_reset_midflight;
        req0_valid = 1'b1; req0_a = 16'hC000; req0_b = 16'hC000;
        req1_valid = 1'b0;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rmf_grant got=%b exp=1", req0_ready); end
        step;
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || res0_data !== 16'h0000 || res1_data !== 16'h0000) begin n_err++; $display("FAIL rmf_async got=%b/%h/%h exp=0/0000/0000", busy, res0_data, res1_data); end
        step;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            n_cmp++; if ({res0_valid, res1_valid, busy} !== 3'b000) begin n_err++; $display("FAIL rmf_no_result c=%0d got=%b exp=000", c, {res0_valid, res1_valid, busy}); end
        end
        n_cmp++; if (res0_data !== 16'h0000 || res1_data !== 16'h0000) begin n_err++; $display("FAIL rmf_data got=%h/%h exp=0000/0000", res0_data, res1_data); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rmf_prio got=%b exp=10", {req0_ready, req1_ready}); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_saturation;
        test_contention;
        test_en_gating;
        test_reset_midflight;
        step; step; step; step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
